// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryption core with on-the-fly key expansion.
// UNROLL rounds (1, 2, 5 or 10) are evaluated per clock in a combinational chain.
module aes128_enc_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic [127:0] block_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] block_out,
  output logic [127:0] last_key,
  output logic         busy
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
      $error("aes128_enc_core: UNROLL must be 1, 2, 5 or 10");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // Round primitives. Byte n of a 128-bit word is bits [127-8n -: 8]; the state
  // is column-major, so byte n sits at row n%4, column n/4.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic is_final);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!is_final) t = mix_columns(t);
    return add_round_key(t, k);
  endfunction

  // The rotated w3 rides in the top word of a sub_bytes call; the rest is don't-care.
  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [127:0] sb;
    logic [31:0]  temp, w0, w1, w2, w3;
    sb   = sub_bytes({k[23:0], k[31:24], 96'h0});
    temp = sb[127:96] ^ {rcon, 24'h0};
    w0   = k[127:96] ^ temp;
    w1   = k[95:64] ^ w0;
    w2   = k[63:32] ^ w1;
    w3   = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and round chain
  // ---------------------------------------------------------------------------
  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [UNROLL:0][127:0] s_chain;
  logic [UNROLL:0][127:0] k_chain;

  assign s_chain[0] = state_q;
  assign k_chain[0] = rk_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_stage
    logic [3:0] rnd_g;
    assign rnd_g          = rnd_q + 4'(g);
    assign k_chain[g + 1] = expand_key(k_chain[g], rcon_of(rnd_g));
    assign s_chain[g + 1] = aes_round(s_chain[g], k_chain[g + 1], rnd_g == 4'd10);
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid and its data hold steady until that edge.
  assign in_ready  = (fsm_q == ST_IDLE) && !rst;
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
  assign block_out = state_q;
  assign last_key  = rk_q;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = block_in ^ key_in;
          rk_d    = key_in;
          rnd_d   = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = s_chain[UNROLL];
        rk_d    = k_chain[UNROLL];
        rnd_d   = rnd_q + 4'(UNROLL);
        if (rnd_q + 4'(UNROLL) == 4'd11) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_aes128_enc_core.sv
// Bench for aes128_enc_core: four instances (UNROLL 1, 2, 5, 10) against a
// byte-array AES model with a fully precomputed key schedule.
module tb_aes128_enc_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid  [4];
  logic         in_ready  [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic         busy      [4];
  logic [127:0] key_in    [4];
  logic [127:0] block_in  [4];
  logic [127:0] block_out [4];
  logic [127:0] last_key  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes128_enc_core #(.UNROLL(U)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .key_in    (key_in[g]),
      .block_in  (block_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .block_out (block_out[g]),
      .last_key  (last_key[g]),
      .busy      (busy[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int lat_of [4] = '{10, 5, 2, 1};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] sbox_t [256];

  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {ciphertext, round-10 key}.
  function automatic logic [255:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]] ^ rc, sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ key[127-8*n -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox_t[s[n]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) ct[127-8*n -: 8] = s[n];
    return {ct, w[40], w[41], w[42], w[43]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (entered at a negedge)
  // ---------------------------------------------------------------------------
  task automatic accept(input int d, input logic [127:0] k, input logic [127:0] p);
    int t;
    t = 0;
    key_in[d]   = k;
    block_in[d] = p;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("accept_ok", 128'(t < 200), 128'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  // Counts edges from acceptance until out_valid is seen at a negedge.
  task automatic wait_out(input int d, input bit scramble, output int lat);
    lat = 0;
    do begin
      if (scramble) begin
        key_in[d]   = rnd128();
        block_in[d] = rnd128();
        in_valid[d] = 1'b1;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid[d] && lat < 100);
    in_valid[d] = 1'b0;
  endtask

  task automatic finish_out(input int d, input string tag);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ovalid_after"}, 128'(out_valid[d]), 128'd0);
    check_eq({tag, "_busy_after"},   128'(busy[d]),      128'd0);
    check_eq({tag, "_iready_after"}, 128'(in_ready[d]),  128'd1);
  endtask

  task automatic run_vector(input int d, input logic [127:0] k, input logic [127:0] p,
                            input logic [127:0] exp_ct, input logic [127:0] exp_lk,
                            input bit scramble, input string tag);
    int lat;
    accept(d, k, p);
    wait_out(d, scramble, lat);
    check_eq({tag, "_latency"}, 128'(lat), 128'(lat_of[d]));
    check_eq({tag, "_block_out"}, block_out[d], exp_ct);
    check_eq({tag, "_last_key"}, last_key[d], exp_lk);
    check_eq({tag, "_busy_done"}, 128'(busy[d]), 128'd1);
    finish_out(d, tag);
  endtask

  // Random stream with gaps on both sides, scored in order.
  task automatic stream(input int d);
    logic [255:0] exp_q [$];
    logic [255:0] e;
    int got;
    got = 0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          logic [127:0] k, p;
          k = rnd128();
          p = rnd128();
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          accept(d, k, p);
          exp_q.push_back(aes_ref(k, p));
        end
      end
      begin
        int t;
        t = 0;
        while (got < 50 && t < 5000) begin
          @(negedge clk);
          t++;
          out_ready[d] = ($urandom_range(0, 2) != 0);
          if (out_valid[d] && out_ready[d]) begin
            if (exp_q.size() == 0) begin
              check_eq("stream_unexpected", 128'(exp_q.size()), 128'd1);
            end else begin
              e = exp_q.pop_front();
              check_eq("stream_block_out", block_out[d], e[255:128]);
              check_eq("stream_last_key", last_key[d], e[127:0]);
            end
            got++;
          end
        end
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        check_eq("stream_count", 128'(got), 128'd50);
      end
    join
    check_eq("stream_leftover", 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] e;
    logic [127:0] k, p;
    int lat;
    bit seen_ov;

    init_sbox();
    for (int d = 0; d < 4; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      key_in[d]    = '0;
      block_in[d]  = '0;
    end

    // Clock/reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check_eq("rst_in_ready",  128'(in_ready[d]),  128'd0);
      check_eq("rst_out_valid", 128'(out_valid[d]), 128'd0);
      check_eq("rst_busy",      128'(busy[d]),      128'd0);
      check_eq("rst_block_out", block_out[d],       128'd0);
      check_eq("rst_last_key",  last_key[d],        128'd0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) check_eq("post_rst_in_ready", 128'(in_ready[d]), 128'd1);
    @(negedge clk);

    // FIPS-197 C.1 on UNROLL=1
    run_vector(0, C1_KEY, C1_PT, C1_CT, C1_LK, 1'b0, "c1");

    // FIPS-197 App. B on every unroll factor
    e = aes_ref(B_KEY, B_PT);
    for (int d = 0; d < 4; d++) run_vector(d, B_KEY, B_PT, B_CT, e[127:0], 1'b0, "appb");

    // Backpressure: hold DONE for 20 cycles with a competing in_valid pending
    k = rnd128();
    p = rnd128();
    e = aes_ref(k, p);
    accept(0, k, p);
    wait_out(0, 1'b0, lat);
    check_eq("bp_latency", 128'(lat), 128'd10);
    key_in[0]   = rnd128();
    block_in[0] = rnd128();
    in_valid[0] = 1'b1;
    repeat (20) begin
      check_eq("bp_block_out", block_out[0], e[255:128]);
      check_eq("bp_last_key",  last_key[0],  e[127:0]);
      check_eq("bp_in_ready",  128'(in_ready[0]),  128'd0);
      check_eq("bp_out_valid", 128'(out_valid[0]), 128'd1);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    @(negedge clk);
    check_eq("bp_in_ready_after",  128'(in_ready[0]),  128'd1);
    check_eq("bp_out_valid_after", 128'(out_valid[0]), 128'd0);

    // Reset while RUN holds rnd=4
    seen_ov = 1'b0;
    @(negedge clk);
    accept(0, C1_KEY, C1_PT);
    repeat (3) begin
      @(negedge clk);
      seen_ov |= out_valid[0];
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    seen_ov |= out_valid[0];
    check_eq("midrst_in_ready_in_rst", 128'(in_ready[0]), 128'd0);
    rst = 1'b0;
    #1;
    check_eq("midrst_busy",      128'(busy[0]),     128'd0);
    check_eq("midrst_in_ready",  128'(in_ready[0]), 128'd1);
    check_eq("midrst_block_out", block_out[0],      128'd0);
    check_eq("midrst_last_key",  last_key[0],       128'd0);
    repeat (12) begin
      @(negedge clk);
      seen_ov |= out_valid[0];
    end
    check_eq("midrst_no_out_valid", 128'(seen_ov), 128'd0);

    // C.1 again, with inputs scrambled every cycle of RUN
    run_vector(0, C1_KEY, C1_PT, C1_CT, C1_LK, 1'b1, "c1_scramble");

    // Randomized streams on every unroll factor
    for (int d = 0; d < 4; d++) stream(d);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
